burst_ram_arbiter: RTL and testbench

BURST_RAM_ARBITER -- requirements
Module: burst_ram_arbiter

---
 rtl/burst_ram_arbiter.sv | 138 +++++++++++++
 tb/tb_burst_ram_arbiter.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_ram_arbiter.sv
// Two-port round-robin arbiter in front of a burst RAM controller.
// Each grant issues one burst command; writes stream BURST_COUNT beats
// from the owner, reads forward BURST_COUNT returned beats to the owner.
module burst_ram_arbiter #(
    parameter int DEPTH_BITWIDTH = 4,
    parameter int BURST_COUNT    = 4
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      p0_req,
    input  logic                      p0_cmd,
    input  logic [DEPTH_BITWIDTH-1:0] p0_addr,
    input  logic [63:0]               p0_wr_data,
    output logic                      p0_ack,
    output logic                      p0_wr_take,
    output logic                      p0_rd_data_valid,

    input  logic                      p1_req,
    input  logic                      p1_cmd,
    input  logic [DEPTH_BITWIDTH-1:0] p1_addr,
    input  logic [63:0]               p1_wr_data,
    output logic                      p1_ack,
    output logic                      p1_wr_take,
    output logic                      p1_rd_data_valid,

    output logic [63:0]               rd_data,

    output logic                      br_cmd,
    output logic                      br_cmd_en,
    output logic [DEPTH_BITWIDTH-1:0] br_addr,
    output logic [63:0]               br_wr_data,
    output logic [7:0]                br_data_mask,
    input  logic [63:0]               br_rd_data,
    input  logic                      br_rd_data_valid,
    input  logic                      br_busy,
    input  logic                      br_init_calib
);

    localparam int CW = $clog2(BURST_COUNT);
    localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_COUNT - 1);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ
    } state_t;

    state_t          state;
    logic [CW-1:0]   beat_cnt;
    logic            owner;
    logic            last_owner;
    logic            grant_ok;
    logic            winner;
    logic            wr_active;
    logic            rd_beat;

    // Round-robin pick: the sole requester, or the port that did not win last.
    always_comb begin
        grant_ok = br_init_calib && !br_busy && (p0_req || p1_req);
        if (p0_req && p1_req) begin
            winner = ~last_owner;
        end else begin
            winner = p1_req;
        end
    end

    // Arbitration/burst sequencer with registered command and ack outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            beat_cnt   <= '0;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            br_cmd_en  <= 1'b0;
            br_cmd     <= 1'b0;
            br_addr    <= '0;
            p0_ack     <= 1'b0;
            p1_ack     <= 1'b0;
        end else begin
            br_cmd_en <= 1'b0;
            p0_ack    <= 1'b0;
            p1_ack    <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_ok) begin
                        owner      <= winner;
                        last_owner <= winner;
                        br_cmd_en  <= 1'b1;
                        p0_ack     <= ~winner;
                        p1_ack     <= winner;
                        br_cmd     <= winner ? p1_cmd : p0_cmd;
                        br_addr    <= winner ? p1_addr : p0_addr;
                        beat_cnt   <= '0;
                        state      <= (winner ? p1_cmd : p0_cmd) ? WRITE : READ;
                    end
                end
                WRITE: begin
                    // The command cycle is beat 0, so WRITE lasts exactly BURST_COUNT cycles.
                    if (beat_cnt == LAST_BEAT) begin
                        beat_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        beat_cnt <= beat_cnt + CW'(1);
                    end
                end
                READ: begin
                    if (br_rd_data_valid) begin
                        if (beat_cnt == LAST_BEAT) begin
                            beat_cnt <= '0;
                            state    <= IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + CW'(1);
                        end
                    end
                end
                default: begin
                    beat_cnt <= '0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    // Data-path steering toward the current owner only.
    always_comb begin
        wr_active        = (state == WRITE);
        rd_beat          = (state == READ) && br_rd_data_valid;
        p0_wr_take       = wr_active && !owner;
        p1_wr_take       = wr_active && owner;
        p0_rd_data_valid = rd_beat && !owner;
        p1_rd_data_valid = rd_beat && owner;
        br_wr_data       = owner ? p1_wr_data : p0_wr_data;
        rd_data          = br_rd_data;
        br_data_mask     = '0;
    end

endmodule

// File: tb/tb_burst_ram_arbiter.sv
// Directed bench for burst_ram_arbiter with a burst RAM emulator,
// a remaining-beats reference model and a per-cycle output compare.
module tb_burst_ram_arbiter;

    localparam int DW = 4;
    localparam int BC = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          p0_req = 1'b0, p0_cmd = 1'b0;
    logic [DW-1:0] p0_addr = '0;
    logic [63:0]   p0_wr_data = '0;
    logic          p0_ack, p0_wr_take, p0_rd_data_valid;
    logic          p1_req = 1'b0, p1_cmd = 1'b0;
    logic [DW-1:0] p1_addr = '0;
    logic [63:0]   p1_wr_data = '0;
    logic          p1_ack, p1_wr_take, p1_rd_data_valid;
    logic [63:0]   rd_data;
    logic          br_cmd, br_cmd_en;
    logic [DW-1:0] br_addr;
    logic [63:0]   br_wr_data;
    logic [7:0]    br_data_mask;
    logic [63:0]   br_rd_data = '0;
    logic          br_rd_data_valid = 1'b0;
    logic          br_busy = 1'b0;
    logic          br_init_calib = 1'b0;

    burst_ram_arbiter #(.DEPTH_BITWIDTH(DW), .BURST_COUNT(BC)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_cmd(p0_cmd), .p0_addr(p0_addr), .p0_wr_data(p0_wr_data),
        .p0_ack(p0_ack), .p0_wr_take(p0_wr_take), .p0_rd_data_valid(p0_rd_data_valid),
        .p1_req(p1_req), .p1_cmd(p1_cmd), .p1_addr(p1_addr), .p1_wr_data(p1_wr_data),
        .p1_ack(p1_ack), .p1_wr_take(p1_wr_take), .p1_rd_data_valid(p1_rd_data_valid),
        .rd_data(rd_data),
        .br_cmd(br_cmd), .br_cmd_en(br_cmd_en), .br_addr(br_addr),
        .br_wr_data(br_wr_data), .br_data_mask(br_data_mask),
        .br_rd_data(br_rd_data), .br_rd_data_valid(br_rd_data_valid),
        .br_busy(br_busy), .br_init_calib(br_init_calib)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_bound(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // ---------------- burst RAM emulator ----------------
    logic [63:0]   mem [16];
    logic [63:0]   wbuf0 [4];
    logic [63:0]   wbuf1 [4];
    logic          inject = 1'b0;

    // Write capture (pre-edge values) and memory initialisation.
    initial begin
        int wn;
        logic [DW-1:0] wa;
        wn = 0;
        wa = '0;
        for (int i = 0; i < 16; i++) mem[i] = 64'h1000_0000_0000_0000 + 64'(i) * 64'h0101;
        forever begin
            @(posedge clk);
            if (br_cmd_en && br_cmd) begin
                wn = BC;
                wa = br_addr;
            end
            if (wn > 0) begin
                mem[wa] = br_wr_data;
                wa = wa + 1'b1;
                wn--;
            end
        end
    end

    // Read responder: 2-cycle latency, one idle gap after the second beat.
    initial begin
        int r_left, r_delay;
        logic [DW-1:0] r_addr;
        logic emu_valid;
        logic [63:0] emu_data;
        r_left = 0; r_delay = 0; r_addr = '0; emu_data = '0;
        forever begin
            @(negedge clk);
            emu_valid = 1'b0;
            if (br_cmd_en && !br_cmd) begin
                r_left = BC;
                r_addr = br_addr;
                r_delay = 2;
            end else if (r_left > 0) begin
                if (r_delay > 0) begin
                    r_delay--;
                end else begin
                    emu_valid = 1'b1;
                    emu_data = mem[r_addr];
                    r_addr = r_addr + 1'b1;
                    r_left--;
                    if (r_left == 2) r_delay = 1;
                end
            end
            br_rd_data_valid = emu_valid | inject;
            br_rd_data = inject ? 64'hDEAD_BEEF_DEAD_BEEF : emu_data;
        end
    end

    // Requester write-data servers: present the next beat whenever taken.
    initial begin
        int k0, k1;
        k0 = 0; k1 = 0;
        forever begin
            @(negedge clk);
            if (p0_ack) k0 = 0;
            if (p1_ack) k1 = 0;
            if (p0_wr_take && k0 < 4) begin p0_wr_data = wbuf0[k0]; k0++; end
            if (p1_wr_take && k1 < 4) begin p1_wr_data = wbuf1[k1]; k1++; end
        end
    end

    // ---------------- reference model ----------------
    // Tracks beats still owed in the running burst; a grant happens only
    // when nothing is owed, the RAM is ready and someone requests.
    logic          m_cmd_en, m_cmd, m_ack0, m_ack1, m_owner, m_last;
    logic [DW-1:0] m_addr;
    int            m_wr_left, m_rd_left;

    initial begin
        logic idle, win;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_cmd_en = 0; m_cmd = 0; m_ack0 = 0; m_ack1 = 0; m_addr = '0;
                m_owner = 0; m_last = 1; m_wr_left = 0; m_rd_left = 0;
            end else begin
                idle = (m_wr_left == 0) && (m_rd_left == 0);
                if (m_wr_left > 0) m_wr_left--;
                if (m_rd_left > 0 && br_rd_data_valid) m_rd_left--;
                m_cmd_en = 0; m_ack0 = 0; m_ack1 = 0;
                if (idle && br_init_calib && !br_busy && (p0_req || p1_req)) begin
                    win = (p0_req && p1_req) ? !m_last : p1_req;
                    m_owner = win; m_last = win;
                    m_cmd_en = 1; m_ack0 = !win; m_ack1 = win;
                    m_cmd = win ? p1_cmd : p0_cmd;
                    m_addr = win ? p1_addr : p0_addr;
                    if (m_cmd) m_wr_left = BC; else m_rd_left = BC;
                end
            end
        end
    end

    // ---------------- per-cycle compare and logging ----------------
    logic [63:0] q0[$], q1[$], take0[$], take1[$];
    int          take0_cyc[$], ack_port[$], ack_cyc[$];
    int          cyc = 0;

    initial begin
        logic wr_on, rd_on;
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            wr_on = (m_wr_left > 0);
            rd_on = (m_rd_left > 0) && br_rd_data_valid;
            chk("br_cmd_en", 64'(br_cmd_en), 64'(m_cmd_en));
            chk("br_cmd", 64'(br_cmd), 64'(m_cmd));
            chk("br_addr", 64'(br_addr), 64'(m_addr));
            chk("p0_ack", 64'(p0_ack), 64'(m_ack0));
            chk("p1_ack", 64'(p1_ack), 64'(m_ack1));
            chk("p0_wr_take", 64'(p0_wr_take), 64'(wr_on && !m_owner));
            chk("p1_wr_take", 64'(p1_wr_take), 64'(wr_on && m_owner));
            chk("p0_rd_valid", 64'(p0_rd_data_valid), 64'(rd_on && !m_owner));
            chk("p1_rd_valid", 64'(p1_rd_data_valid), 64'(rd_on && m_owner));
            chk("rd_data", rd_data, br_rd_data);
            chk("data_mask", 64'(br_data_mask), 64'd0);
            if (wr_on) chk("br_wr_data", br_wr_data, m_owner ? p1_wr_data : p0_wr_data);
            if (p0_rd_data_valid) q0.push_back(rd_data);
            if (p1_rd_data_valid) q1.push_back(rd_data);
            if (p0_wr_take) begin take0.push_back(br_wr_data); take0_cyc.push_back(cyc); end
            if (p1_wr_take) take1.push_back(br_wr_data);
            if (p0_ack) begin ack_port.push_back(0); ack_cyc.push_back(cyc); end
            if (p1_ack) begin ack_port.push_back(1); ack_cyc.push_back(cyc); end
        end
    end

    // ---------------- directed flow ----------------
    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic wait_ack(input int port, input int bound, output int lat, input string name);
        lat = -1;
        for (int i = 1; i <= bound; i++) begin
            step();
            if ((port == 0 && p0_ack) || (port == 1 && p1_ack)) begin
                lat = i;
                break;
            end
        end
        if (lat < 0) fail_bound(name);
    endtask

    task automatic wait_beats(input int port, input int target, input int bound, input string name);
        for (int i = 0; i < bound; i++) begin
            if ((port == 0 ? q0.size() : q1.size()) >= target) break;
            step();
        end
        if ((port == 0 ? q0.size() : q1.size()) < target) fail_bound(name);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int lat, cnt, b0, b1, tb0, tb1, ab, ac;

    initial begin
        logic [63:0] exp_w [4];
        exp_w[0] = 64'h11; exp_w[1] = 64'h22; exp_w[2] = 64'h33; exp_w[3] = 64'h44;
        for (int i = 0; i < 4; i++) begin
            wbuf0[i] = exp_w[i];
            wbuf1[i] = 64'hA1 + 64'(i);
        end

        // Reset state
        repeat (3) step();
        chk("rst_br_cmd_en", 64'(br_cmd_en), 64'd0);
        chk("rst_p0_ack", 64'(p0_ack), 64'd0);
        chk("rst_br_addr", 64'(br_addr), 64'd0);
        rst = 1'b0;

        // Calibration gate
        p0_cmd = 1'b0; p0_addr = 4'd2; p0_req = 1'b1;
        cnt = 0;
        repeat (10) begin step(); if (br_cmd_en) cnt++; end
        chk("calib_no_cmd", 64'(cnt), 64'd0);
        br_init_calib = 1'b1;
        wait_ack(0, 5, lat, "calib_ack");
        chk("calib_ack_latency", 64'(lat), 64'd1);
        chk("calib_cmd_en", 64'(br_cmd_en), 64'd1);
        chk("calib_addr", 64'(br_addr), 64'd2);
        chk("calib_cmd", 64'(br_cmd), 64'd0);
        p0_req = 1'b0;
        wait_beats(0, 4, 20, "calib_read_beats");
        if (q0.size() >= 4) begin
            chk("calib_rd0", q0[0], 64'h1000_0000_0000_0202);
            chk("calib_rd3", q0[3], 64'h1000_0000_0000_0505);
        end
        repeat (3) step();

        // p1 read of 4 beats, then immediate p0 request to probe IDLE re-entry
        b0 = q0.size(); b1 = q1.size();
        p1_cmd = 1'b0; p1_addr = 4'd5; p1_req = 1'b1;
        wait_ack(1, 5, lat, "p1_read_ack");
        chk("p1_read_ack_latency", 64'(lat), 64'd1);
        p1_req = 1'b0;
        wait_beats(1, b1 + 4, 20, "p1_read_beats");
        p0_cmd = 1'b0; p0_addr = 4'd0; p0_req = 1'b1;
        wait_ack(0, 5, lat, "after_read_ack");
        chk("idle_after_beat4_latency", 64'(lat), 64'd2);
        p0_req = 1'b0;
        wait_beats(0, b0 + 4, 20, "p0_read_beats");
        repeat (3) step();
        chk("p1_read_count", 64'(q1.size()), 64'(b1 + 4));
        chk("p0_read_count", 64'(q0.size()), 64'(b0 + 4));
        if (q1.size() >= b1 + 4) begin
            chk("p1_rd0", q1[b1], 64'h1000_0000_0000_0505);
            chk("p1_rd1", q1[b1+1], 64'h1000_0000_0000_0606);
            chk("p1_rd2", q1[b1+2], 64'h1000_0000_0000_0707);
            chk("p1_rd3", q1[b1+3], 64'h1000_0000_0000_0808);
        end

        // Stray read-valid while idle is ignored
        b0 = q0.size(); b1 = q1.size();
        inject = 1'b1;
        repeat (2) step();
        inject = 1'b0;
        repeat (2) step();
        chk("stray_valid_p0", 64'(q0.size()), 64'(b0));
        chk("stray_valid_p1", 64'(q1.size()), 64'(b1));

        // p0 write burst, then read back
        tb0 = take0.size(); ac = ack_cyc.size();
        p0_cmd = 1'b1; p0_addr = 4'd3; p0_req = 1'b1;
        wait_ack(0, 5, lat, "write_ack");
        p0_req = 1'b0;
        repeat (6) step();
        chk("write_take_count", 64'(take0.size()), 64'(tb0 + 4));
        if (take0.size() >= tb0 + 4 && ack_cyc.size() > ac) begin
            chk("write_take_starts_at_cmd", 64'(take0_cyc[tb0]), 64'(ack_cyc[ac]));
            chk("write_take_consecutive", 64'(take0_cyc[tb0+3] - take0_cyc[tb0]), 64'd3);
            for (int i = 0; i < 4; i++) chk("write_beat", take0[tb0+i], exp_w[i]);
        end
        chk("mem3", mem[3], 64'h11);
        chk("mem6", mem[6], 64'h44);
        b0 = q0.size();
        p0_cmd = 1'b0; p0_addr = 4'd3; p0_req = 1'b1;
        wait_ack(0, 5, lat, "readback_ack");
        p0_req = 1'b0;
        wait_beats(0, b0 + 4, 20, "readback_beats");
        if (q0.size() >= b0 + 4)
            for (int i = 0; i < 4; i++) chk("readback_beat", q0[b0+i], exp_w[i]);
        repeat (3) step();

        // Contention after reset: p0 first, then strict alternation
        rst = 1'b1; repeat (2) step(); rst = 1'b0;
        ab = ack_port.size();
        p0_cmd = 1'b0; p0_addr = 4'd1; p1_cmd = 1'b0; p1_addr = 4'd9;
        p0_req = 1'b1; p1_req = 1'b1;
        for (int i = 0; i < 300 && ack_port.size() < ab + 4; i++) step();
        p0_req = 1'b0; p1_req = 1'b0;
        if (ack_port.size() < ab + 4) fail_bound("contention_grants");
        repeat (20) step();
        chk("contention_grant_count", 64'(ack_port.size()), 64'(ab + 4));
        if (ack_port.size() >= ab + 4) begin
            chk("grant0", 64'(ack_port[ab]), 64'd0);
            chk("grant1", 64'(ack_port[ab+1]), 64'd1);
            chk("grant2", 64'(ack_port[ab+2]), 64'd0);
            chk("grant3", 64'(ack_port[ab+3]), 64'd1);
        end

        // Busy holds off both requesters
        tb1 = take1.size();
        br_busy = 1'b1;
        p0_cmd = 1'b0; p0_addr = 4'd0; p1_cmd = 1'b1; p1_addr = 4'd12;
        p0_req = 1'b1; p1_req = 1'b1;
        cnt = 0;
        repeat (6) begin step(); if (br_cmd_en) cnt++; end
        chk("busy_no_cmd", 64'(cnt), 64'd0);
        br_busy = 1'b0;
        wait_ack(0, 3, lat, "busy_release_ack");
        chk("busy_grant_within_2", 64'(lat >= 1 && lat <= 2), 64'd1);
        p0_req = 1'b0;
        wait_ack(1, 40, lat, "p1_write_ack");
        p1_req = 1'b0;
        repeat (8) step();
        chk("p1_take_count", 64'(take1.size()), 64'(tb1 + 4));
        if (take1.size() >= tb1 + 4) begin
            chk("p1_take0", take1[tb1], 64'hA1);
            chk("p1_take3", take1[tb1+3], 64'hA4);
        end
        chk("mem12", mem[12], 64'hA1);
        chk("mem15", mem[15], 64'hA4);

        // Reset in the middle of a read, then a clean read
        b1 = q1.size();
        p1_cmd = 1'b0; p1_addr = 4'd5; p1_req = 1'b1;
        wait_ack(1, 5, lat, "midreset_ack");
        p1_req = 1'b0;
        wait_beats(1, b1 + 2, 20, "midreset_beats");
        rst = 1'b1;
        step();
        chk("midrst_cmd_en", 64'(br_cmd_en), 64'd0);
        chk("midrst_p1_rd_valid", 64'(p1_rd_data_valid), 64'd0);
        chk("midrst_p1_ack", 64'(p1_ack), 64'd0);
        chk("midrst_br_addr", 64'(br_addr), 64'd0);
        repeat (2) step();
        rst = 1'b0;
        repeat (4) step();
        chk("midrst_no_more_beats", 64'(q1.size()), 64'(b1 + 2));
        b1 = q1.size();
        p1_req = 1'b1;
        wait_ack(1, 5, lat, "post_reset_ack");
        chk("post_reset_ack_latency", 64'(lat), 64'd1);
        p1_req = 1'b0;
        wait_beats(1, b1 + 4, 20, "post_reset_beats");
        if (q1.size() >= b1 + 4) begin
            chk("post_rd0", q1[b1], 64'h33);
            chk("post_rd1", q1[b1+1], 64'h44);
            chk("post_rd2", q1[b1+2], 64'h1000_0000_0000_0707);
            chk("post_rd3", q1[b1+3], 64'h1000_0000_0000_0808);
        end
        repeat (5) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
